// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states and access-size decode.
package lsu_ctrl_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } mem_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2
  } mem_st_funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } acc_size_e;

  // Any funct3 outside the defined set falls back to a word access.
  function automatic acc_size_e acc_size(input logic [2:0] f3, input logic store);
    acc_size_e sz;
    sz = SZ_W;
    if (store) begin
      if (f3 == SB) sz = SZ_B;
      else if (f3 == SH) sz = SZ_H;
    end else begin
      if (f3 == LB || f3 == LBU) sz = SZ_B;
      else if (f3 == LH || f3 == LHU) sz = SZ_H;
    end
    return sz;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
    return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: selects the addressed byte/halfword of the raw
// memory word and sign- or zero-extends it; word loads pass straight through.
module lsu_load_align import lsu_ctrl_pkg::*; #(
  parameter int P_DW = 32
) (
  input  logic [P_DW-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [P_DW-1:0] data
);

  logic [P_DW-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      LB:      data = {{(P_DW-8){shifted[7]}}, shifted[7:0]};
      LH:      data = {{(P_DW-16){shifted[15]}}, shifted[15:0]};
      LBU:     data = {{(P_DW-8){1'b0}}, shifted[7:0]};
      LHU:     data = {{(P_DW-16){1'b0}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns the pipeline's held rd/wr command into one valid/ready
// memory transaction. Store 3 cycles, load 4 cycles at zero wait; o_stall holds the pipe meanwhile.
module lsu_ctrl import lsu_ctrl_pkg::*; #(
  parameter int P_DW      = 32,
  parameter int P_TIMEOUT = 255,
  parameter int P_CNT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_rd,
  input  logic            i_mem_wr,
  input  logic [2:0]      i_funct3,
  input  logic [P_DW-1:0] i_addr,
  input  logic [P_DW-1:0] i_wdata,
  output logic            o_dmem_valid,
  input  logic            i_dmem_ready,
  output logic            o_dmem_we,
  output logic [P_DW-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [P_DW-1:0] o_dmem_wdata,
  input  logic            i_dmem_rvalid,
  input  logic [P_DW-1:0] i_dmem_rdata,
  output logic [P_DW-1:0] o_load_data,
  output logic            o_load_valid,
  output logic            o_stall,
  output logic            o_misalign,
  output logic            o_bus_err
);

  localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_TIMEOUT - 1);

  lsu_state_e         state;
  logic [P_CNT_W-1:0] cnt;
  logic [2:0]         funct3_q;
  logic [1:0]         offset_q;
  logic               stall_q;

  acc_size_e          size;
  logic               cmd;
  logic               mis;
  logic               start;
  logic [3:0]         be_next;
  logic [P_DW-1:0]    wdata_next;
  logic [P_DW-1:0]    load_fmt;

  always_comb begin
    cmd        = i_mem_rd | i_mem_wr;
    size       = acc_size(i_funct3, i_mem_wr);
    mis        = cmd & misaligned(size, i_addr[1:0]);
    start      = (state == IDLE) & cmd & ~mis;
    be_next    = 4'b1111;
    wdata_next = i_wdata;
    case (size)
      SZ_B: begin
        be_next    = 4'b0001 << i_addr[1:0];
        wdata_next = {(P_DW/8){i_wdata[7:0]}};
      end
      SZ_H: begin
        be_next    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {(P_DW/16){i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Misalignment and the first stall cycle must be seen by the pipeline in the same cycle.
  assign o_misalign = (state == IDLE) & mis;
  assign o_stall    = stall_q | start;

  lsu_load_align #(.P_DW(P_DW)) u_align (
    .rdata  (i_dmem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (load_fmt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      stall_q      <= 1'b0;
      o_dmem_valid <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= '0;
      o_dmem_wdata <= '0;
      o_load_data  <= '0;
      o_load_valid <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      o_load_valid <= 1'b0;
      o_bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= REQ;
            cnt          <= '0;
            stall_q      <= 1'b1;
            o_dmem_valid <= 1'b1;
            o_dmem_we    <= i_mem_wr;
            o_dmem_addr  <= {i_addr[P_DW-1:2], 2'b00};
            o_dmem_be    <= be_next;
            o_dmem_wdata <= wdata_next;
            funct3_q     <= i_funct3;
            offset_q     <= i_addr[1:0];
          end
        end
        REQ: begin
          if (i_dmem_ready) begin
            o_dmem_valid <= 1'b0;
            cnt          <= '0;
            if (o_dmem_we) begin
              stall_q <= 1'b0;
              state   <= DONE;
            end else begin
              state <= WAIT_R;
            end
          end else if (cnt == CNT_LAST) begin
            o_dmem_valid <= 1'b0;
            o_bus_err    <= 1'b1;
            stall_q      <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_R: begin
          if (i_dmem_rvalid) begin
            o_load_data  <= load_fmt;
            o_load_valid <= 1'b1;
            stall_q      <= 1'b0;
            state        <= DONE;
          end else if (cnt == CNT_LAST) begin
            o_bus_err <= 1'b1;
            stall_q   <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
